mac_stop_accum: RTL and testbench

- Downstream stage of the mac_stop multiplier.
- Consumes the registered product stream (product, product-valid, and the registered row/col indices i, j, k) and accumulates K products into each result element C[i][j].
- Buffers each finished element in a 2-entry result FIFO and presents it on a valid/ready write port to the result-matrix memory.
- Signals matrix completion after the last element (i=M-1, j=N-1) has drained.

---
 rtl/mac_stop_pkg.sv | 11 +
 rtl/mac_stop_result_fifo.sv | 61 ++++++
 rtl/mac_stop_accum.sv | 117 +++++++++++
 tb/tb_mac_stop_accum.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mac_stop_pkg.sv
// Shared types and width helpers for the mac_stop result path.
package mac_stop_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

    // Index ports stay at least one bit wide even for a size-1 dimension.
    function automatic int clog2_safe(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mac_stop_result_fifo.sv
// Small result FIFO between the accumulator and the result-matrix write port.
module mac_stop_result_fifo
    import mac_stop_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = clog2_safe(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push-on-full is accepted then.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mac_stop_accum.sv
// Accumulates K products per C[i][j], buffers finished elements and writes them out.
module mac_stop_accum
    import mac_stop_pkg::*;
#(
    parameter int M = 2,
    parameter int K = 2,
    parameter int N = 2,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = DATA_WIDTH_INIT_MATRIX*2 + $clog2(K)
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [2*DATA_WIDTH_INIT_MATRIX-1:0]   product_in,
    input  logic                                  product_valid,
    input  logic [clog2_safe(M)-1:0]              row_idx,
    input  logic [clog2_safe(N)-1:0]              col_idx,
    input  logic [clog2_safe(K)-1:0]              k_idx,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0]   c_wdata,
    output logic [clog2_safe(M)-1:0]              c_row_addr,
    output logic [clog2_safe(N)-1:0]              c_col_addr,
    output logic                                  c_we,
    input  logic                                  c_ready,
    output logic                                  matrix_done,
    output logic                                  busy,
    output logic                                  seq_err,
    output logic                                  ovf_err
);
    localparam int RW = DATA_WIDTH_RESULT_MATRIX;
    localparam int MW = clog2_safe(M);
    localparam int NW = clog2_safe(N);
    localparam int KW = clog2_safe(K);

    typedef struct packed {
        logic [RW-1:0] data;
        logic [MW-1:0] row;
        logic [NW-1:0] col;
    } result_entry_t;

    state_e        state_q, state_d;
    logic [RW-1:0] acc_q, acc_d, acc_sum;
    logic [KW-1:0] kexp_q, kexp_d;
    logic          seq_err_q, seq_err_d, ovf_err_q, ovf_err_d;
    logic          accept, last_k, final_prod, push, pop;
    logic          fifo_full, fifo_empty;
    result_entry_t push_entry, head_entry;

    assign accept     = product_valid && (state_q == IDLE || state_q == ACCUM);
    assign last_k     = (k_idx == KW'(K - 1));
    assign final_prod = accept && last_k && (row_idx == MW'(M - 1)) && (col_idx == NW'(N - 1));
    assign acc_sum    = acc_q + RW'(product_in);
    assign push       = accept && last_k;
    assign pop        = !fifo_empty && c_ready;
    assign push_entry = '{data: acc_sum, row: row_idx, col: col_idx};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        kexp_d    = kexp_q;
        seq_err_d = seq_err_q;
        ovf_err_d = ovf_err_q | (push && fifo_full && !pop);
        if (accept) begin
            // Accumulation trusts k_idx even when it disagrees with the expected count.
            acc_d  = (k_idx == '0) ? RW'(product_in) : acc_sum;
            kexp_d = (kexp_q == KW'(K - 1)) ? '0 : kexp_q + KW'(1);
            if (k_idx != kexp_q) seq_err_d = 1'b1;
        end else if (product_valid) begin
            seq_err_d = 1'b1;
        end
        case (state_q)
            IDLE:    if (accept) state_d = final_prod ? DRAIN : ACCUM;
            ACCUM:   if (final_prod) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            kexp_q    <= '0;
            seq_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            kexp_q    <= kexp_d;
            seq_err_q <= seq_err_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    mac_stop_result_fifo #(
        .DEPTH(2),
        .WIDTH($bits(result_entry_t))
    ) u_fifo (
        .clk  (clk),
        .rst  (resetn),
        .push (push),
        .pop  (pop),
        .din  (push_entry),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (head_entry)
    );

    assign c_wdata     = head_entry.data;
    assign c_row_addr  = head_entry.row;
    assign c_col_addr  = head_entry.col;
    assign c_we        = !fifo_empty;
    assign matrix_done = (state_q == DONE);
    assign busy        = (state_q == ACCUM) || (state_q == DRAIN);
    assign seq_err     = seq_err_q;
    assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_mac_stop_accum.sv
// Directed bench for mac_stop_accum with M=K=N=2 and 8-bit operands.
module tb_mac_stop_accum;
    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [15:0] product_in = '0;
    logic        product_valid = 1'b0;
    logic [0:0]  row_idx = '0, col_idx = '0, k_idx = '0;
    logic [16:0] c_wdata;
    logic [0:0]  c_row_addr, c_col_addr;
    logic        c_we, c_ready = 1'b1;
    logic        matrix_done, busy, seq_err, ovf_err;

    mac_stop_accum #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(8)) dut (
        .clk(clk), .resetn(resetn), .product_in(product_in), .product_valid(product_valid),
        .row_idx(row_idx), .col_idx(col_idx), .k_idx(k_idx), .c_wdata(c_wdata),
        .c_row_addr(c_row_addr), .c_col_addr(c_col_addr), .c_we(c_we), .c_ready(c_ready),
        .matrix_done(matrix_done), .busy(busy), .seq_err(seq_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [16:0] wdq[$];
    logic [1:0]  waq[$];
    logic [15:0] prod_t [8] = '{16'd5, 16'd14, 16'd6, 16'd16, 16'd15, 16'd28, 16'd18, 16'd32};
    logic [16:0] sums [4] = '{17'd19, 17'd22, 17'd43, 17'd50};

    always @(posedge clk) begin
        if (c_we && c_ready) begin
            wdq.push_back(c_wdata);
            waq.push_back({c_row_addr, c_col_addr});
        end
        if (matrix_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_raw(input int i, input int j, input int k, input logic [15:0] p);
        product_valid = 1'b1;
        row_idx = 1'(i);
        col_idx = 1'(j);
        k_idx = 1'(k);
        product_in = p;
        tick();
        product_valid = 1'b0;
    endtask

    task automatic send(input int n);
        send_raw((n >> 2) & 1, (n >> 1) & 1, n & 1, prod_t[n]);
    endtask

    task automatic wait_done(input string tag);
        bit ok = 0;
        for (int t = 0; t < 40; t++) begin
            if (matrix_done) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk({tag, "_done_seen"}, 64'(ok), 64'd1);
        chk({tag, "_no_we_at_done"}, 64'(c_we), 64'd0);
        tick();
        chk({tag, "_done_pulse"}, 64'(matrix_done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic check_results(input string tag, input int n);
        chk({tag, "_count"}, 64'(wdq.size()), 64'(n));
        for (int i = 0; i < n && i < wdq.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 64'(wdq[i]), 64'(sums[i]));
            chk($sformatf("%s_addr%0d", tag, i), 64'(waq[i]), 64'(i));
        end
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        tick();
        tick();
        resetn = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_we", 64'(c_we), 64'd0);
        chk("rst_wdata", 64'(c_wdata), 64'd0);
        chk("rst_done", 64'(matrix_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_errs", 64'({seq_err, ovf_err}), 64'd0);
        resetn = 1'b0;
        tick();

        // Basic matrix, one-cycle latency from last product to c_we
        wdq.delete(); waq.delete(); done_cnt = 0;
        send(0);
        chk("basic_busy", 64'(busy), 64'd1);
        send(1);
        chk("basic_lat_we", 64'(c_we), 64'd1);
        chk("basic_lat_data", 64'(c_wdata), 64'd19);
        for (int n = 2; n < 8; n++) send(n);
        wait_done("basic");
        check_results("basic", 4);
        chk("basic_done_cnt", 64'(done_cnt), 64'd1);
        chk("basic_errs", 64'({seq_err, ovf_err}), 64'd0);

        // Backpressure: head held while c_ready is low for 6 c_we cycles
        wdq.delete(); waq.delete();
        c_ready = 1'b0;
        send(0);
        send(1);
        chk("bp_hold_data0", 64'(c_wdata), 64'd19);
        send(2);
        chk("bp_hold_we1", 64'(c_we), 64'd1);
        send(3);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("bp_hold_data%0d", c + 2), 64'({c_we, c_row_addr, c_col_addr, c_wdata}),
                64'({1'b1, 2'b00, 17'd19}));
        end
        chk("bp_done_low", 64'(matrix_done), 64'd0);
        c_ready = 1'b1;
        for (int n = 4; n < 8; n++) send(n);
        wait_done("bp");
        check_results("bp", 4);
        chk("bp_ovf", 64'(ovf_err), 64'd0);

        // Overflow: third push into a full FIFO is dropped
        wdq.delete(); waq.delete();
        c_ready = 1'b0;
        for (int n = 0; n < 4; n++) send(n);
        chk("ovf_full_no_err", 64'(ovf_err), 64'd0);
        send(4);
        send(5);
        chk("ovf_set", 64'(ovf_err), 64'd1);
        send(6);
        send(7);
        c_ready = 1'b1;
        wait_done("ovf");
        check_results("ovf", 2);
        chk("ovf_sticky", 64'(ovf_err), 64'd1);
        do_reset();
        chk("ovf_cleared", 64'(ovf_err), 64'd0);

        // Sequence error: k_idx=1 as first product
        send_raw(0, 0, 1, 16'd14);
        chk("seq_set", 64'(seq_err), 64'd1);
        tick();
        tick();
        chk("seq_sticky", 64'(seq_err), 64'd1);
        do_reset();
        chk("seq_cleared", 64'(seq_err), 64'd0);

        // Mid-operation reset discards everything
        for (int n = 0; n < 3; n++) send(n);
        wdq.delete(); waq.delete();
        resetn = 1'b1;
        #1;
        chk("mid_rst_outs", 64'({c_we, busy, matrix_done, c_row_addr, c_col_addr}), 64'd0);
        chk("mid_rst_wdata", 64'(c_wdata), 64'd0);
        tick();
        resetn = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_rst_no_write", 64'(wdq.size()), 64'd0);
        for (int n = 0; n < 8; n++) send(n);
        wait_done("mid");
        check_results("mid", 4);

        // Max product value, no truncation
        send_raw(0, 0, 0, 16'hFE01);
        c_ready = 1'b0;
        send_raw(0, 0, 1, 16'hFE01);
        chk("max_data", 64'(c_wdata), 64'h1FC02);
        chk("max_we", 64'(c_we), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
